// File: rtl/prefix_addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined prefix adder/subtractor.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready close the valid/ready loop on each side.
//
// Ports (per direction):
//   in_valid/in_ready, a, b, cin, op            -- operand beat towards the adder
//   out_valid/out_ready, sum, cout, ovf         -- result beat from the adder
interface prefix_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // The adder itself.
    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/prefix_addsub_pipe.sv
// Pipelined Sklansky prefix adder/subtractor: op=0 a+b+cin, op=1 a+~b+!cin.
// Latency: NSTG = 1 + log2(WIDTH)/PIPE_LEVELS cycles from accept to out_valid.
// Backpressure: per-stage valid bits, bubbles collapse; in_ready low only when every stage is full and stalled.
//
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   bus (slave)  operand beat in (in_valid/in_ready, a, b, cin, op),
//                result beat out (out_valid/out_ready, sum, cout, ovf)
module prefix_addsub_pipe #(
    parameter int WIDTH       = 16,
    parameter int PIPE_LEVELS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    prefix_addsub_pipe_if.slave bus
);

    localparam int LOG  = $clog2(WIDTH);
    localparam int NSTG = 1 + LOG / PIPE_LEVELS;

    // One Sklansky level: every bit whose index has bit 'lvl' set combines
    // with the top bit of the preceding 2^lvl block. Partners never have bit
    // 'lvl' set, so they are unchanged within this level.
    function automatic logic [2*WIDTH-1:0] sk_level(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input int               lvl
    );
        logic [WIDTH-1:0] go;
        logic [WIDTH-1:0] po;
        int               j;
        go = g;
        po = p;
        for (int i = 0; i < WIDTH; i++) begin
            if (((i >> lvl) & 1) == 1) begin
                j     = ((i >> lvl) << lvl) - 1;
                go[i] = g[i] | (p[i] & g[j]);
                po[i] = p[i] & p[j];
            end
        end
        return {go, po};
    endfunction

    // ---------------------------------------------------------------
    // Handshake / stage control
    // ---------------------------------------------------------------
    logic [NSTG:1] v_q;
    logic [NSTG:1] adv;
    logic [NSTG:1] ld;
    logic [NSTG:1] v_in;

    // advance[k] resolved from the output backwards through a local
    // variable, so the chain reads only the valid bits and out_ready.
    always_comb begin
        logic nxt;
        adv       = '0;
        nxt       = bus.out_ready;
        adv[NSTG] = bus.out_ready;
        for (int k = NSTG - 1; k >= 1; k--) begin
            nxt    = v_q[k] && (!v_q[k+1] || nxt);
            adv[k] = nxt;
        end
        ld = ~v_q | adv;
    end

    assign v_in         = {v_q[NSTG-1:1], bus.in_valid};
    assign bus.in_ready = ld[1];

    // ---------------------------------------------------------------
    // Datapath registers (no reset needed: qualified by valid bits)
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] g_q  [1:NSTG-1];  // group generate
    logic [WIDTH-1:0] pg_q [1:NSTG-1];  // group propagate
    logic [WIDTH-1:0] p_q  [1:NSTG-1];  // bitwise a^bx, kept for the final xor
    logic [NSTG-1:1]  ci_q;
    logic [NSTG-1:1]  am_q;             // a[MSB]
    logic [NSTG-1:1]  bm_q;             // bx[MSB]

    logic [WIDTH-1:0] bx;
    logic             ci_in;

    assign bx    = bus.op ? ~bus.b : bus.b;
    assign ci_in = bus.op ? ~bus.cin : bus.cin;

    // Prefix levels for stages 2..NSTG, each fed by the previous register.
    logic [WIDTH-1:0] g_nx  [2:NSTG];
    logic [WIDTH-1:0] pg_nx [2:NSTG];

    always_comb begin
        logic [WIDTH-1:0] gt;
        logic [WIDTH-1:0] pt;
        gt = '0;
        pt = '0;
        for (int s = 2; s <= NSTG; s++) begin
            gt = g_q[s-1];
            pt = pg_q[s-1];
            // Fold the carry-in into bit 0 so G[i] ends up as the carry out
            // of bit i including ci.
            if (s == 2) begin
                gt[0] = gt[0] | (pt[0] & ci_q[1]);
            end
            for (int l = 0; l < PIPE_LEVELS; l++) begin
                {gt, pt} = sk_level(gt, pt, (s - 2) * PIPE_LEVELS + l);
            end
            g_nx[s]  = gt;
            pg_nx[s] = pt;
        end
    end

    logic [WIDTH-1:0] sum_nx;
    logic             cout_nx;
    logic             ovf_nx;

    assign sum_nx  = p_q[NSTG-1] ^ {g_nx[NSTG][WIDTH-2:0], ci_q[NSTG-1]};
    assign cout_nx = g_nx[NSTG][WIDTH-1];
    assign ovf_nx  = (am_q[NSTG-1] == bm_q[NSTG-1]) && (sum_nx[WIDTH-1] != am_q[NSTG-1]);

    always_ff @(posedge clk) begin
        if (ld[1] && bus.in_valid) begin
            g_q[1]  <= bus.a & bx;
            pg_q[1] <= bus.a ^ bx;
            p_q[1]  <= bus.a ^ bx;
            ci_q[1] <= ci_in;
            am_q[1] <= bus.a[WIDTH-1];
            bm_q[1] <= bx[WIDTH-1];
        end
        for (int s = 2; s <= NSTG - 1; s++) begin
            if (ld[s] && v_q[s-1]) begin
                g_q[s]  <= g_nx[s];
                pg_q[s] <= pg_nx[s];
                p_q[s]  <= p_q[s-1];
                ci_q[s] <= ci_q[s-1];
                am_q[s] <= am_q[s-1];
                bm_q[s] <= bm_q[s-1];
            end
        end
    end

    // ---------------------------------------------------------------
    // Valid bits and output registers (reset: they are visible outside)
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            v_q <= (v_q & ~ld) | (v_in & ld);
            if (ld[NSTG] && v_q[NSTG-1]) begin
                sum_q  <= sum_nx;
                cout_q <= cout_nx;
                ovf_q  <= ovf_nx;
            end
        end
    end

    assign bus.out_valid = v_q[NSTG];
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
module tb_prefix_addsub_pipe;

    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    prefix_addsub_pipe_if #(.WIDTH(W)) bus ();

    prefix_addsub_pipe #(.WIDTH(W), .PIPE_LEVELS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference result {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic op);
        logic [W-1:0] bx;
        logic [W:0]   full;
        logic         c;
        logic         ov;
        bx   = op ? ~b : b;
        c    = op ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, c};
        ov   = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full};
    endfunction

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.op        = 1'b0;
    endtask

    task automatic beat_data(input int i);
        logic [31:0] iv;
        iv      = i;
        bus.a   = W'(32'h1357 * (i + 1));
        bus.b   = W'(32'h0F0F + i);
        bus.cin = iv[0];
        bus.op  = iv[1];
    endtask

    // Send one beat into an empty pipe and wait (bounded) for its result.
    // Returns with outputs sampled 2 time units after the edge; lat=0 on timeout.
    task automatic issue_one(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic op, output int lat);
        tick;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.op        = op;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle();
        bus.out_ready = 1'b0;
        repeat (3) tick;
        #1;
        checks++;
        if ({bus.out_valid, bus.ovf, bus.cout, bus.sum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b ovf=%b cout=%b sum=%h want all zero",
                     bus.out_valid, bus.ovf, bus.cout, bus.sum);
        end
        rst_n = 1'b1;
        tick;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got in_ready=%b out_valid=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    // Shared body for directed vector tables: vectors {a,b,cin,op} -> {ovf,cout,sum}.
    task automatic test_add;
        logic [W-1:0] ta [3] = '{16'hFFFF, 16'h1234, 16'h8000};
        logic [W-1:0] tb [3] = '{16'h0001, 16'h4321, 16'h8000};
        logic         tc [3] = '{1'b0, 1'b1, 1'b0};
        logic [W+1:0] te [3] = '{{2'b01, 16'h0000}, {2'b00, 16'h5556}, {2'b11, 16'h0000}};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue_one(ta[i], tb[i], tc[i], 1'b0, lat);
            checks++;
            if (lat !== 3) begin
                errors++;
                $display("FAIL add_latency[%0d]: got %0d want 3", i, lat);
            end
            checks++;
            if ({bus.ovf, bus.cout, bus.sum} !== te[i]) begin
                errors++;
                $display("FAIL add_result[%0d]: got ovf=%b cout=%b sum=%h want %h",
                         i, bus.ovf, bus.cout, bus.sum, te[i]);
            end
        end
        tick;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_single_beat: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_sub;
        logic [W-1:0] ta [3] = '{16'h0005, 16'h0010, 16'h0000};
        logic [W-1:0] tb [3] = '{16'h0007, 16'h0003, 16'h0000};
        logic         tc [3] = '{1'b0, 1'b1, 1'b0};
        logic [W+1:0] te [3] = '{{2'b00, 16'hFFFE}, {2'b01, 16'h000C}, {2'b01, 16'h0000}};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue_one(ta[i], tb[i], tc[i], 1'b1, lat);
            checks++;
            if (lat !== 3 || {bus.ovf, bus.cout, bus.sum} !== te[i]) begin
                errors++;
                $display("FAIL sub_result[%0d]: got lat=%0d ovf=%b cout=%b sum=%h want lat=3 %h",
                         i, lat, bus.ovf, bus.cout, bus.sum, te[i]);
            end
        end
    endtask

    task automatic test_ovf;
        logic [W-1:0] ta [3] = '{16'h7FFF, 16'h8000, 16'h7FFF};
        logic [W-1:0] tb [3] = '{16'h0001, 16'h0001, 16'hFFFF};
        logic         to [3] = '{1'b0, 1'b1, 1'b1};
        logic [W+1:0] te [3] = '{{2'b10, 16'h8000}, {2'b11, 16'h7FFF}, {2'b10, 16'h8000}};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue_one(ta[i], tb[i], 1'b0, to[i], lat);
            checks++;
            if (lat !== 3 || {bus.ovf, bus.cout, bus.sum} !== te[i]) begin
                errors++;
                $display("FAIL ovf_result[%0d]: got lat=%0d ovf=%b cout=%b sum=%h want lat=3 %h",
                         i, lat, bus.ovf, bus.cout, bus.sum, te[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W+1:0] q[$];
        logic [W+1:0] exp;
        int sent = 0, got = 0, stalls = 0, first = -1, last = -1, bad = 0;
        for (int c = 0; c < 24; c++) begin
            tick;
            bus.out_ready = 1'b1;
            if (sent < 8) begin
                beat_data(sent);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && !bus.in_ready) stalls++;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, bus.cin, bus.op));
                sent++;
            end
            if (bus.out_valid) begin
                if (first < 0) first = c;
                last = c;
                exp = (q.size() > 0) ? q.pop_front() : '1;
                if ({bus.ovf, bus.cout, bus.sum} !== exp) bad++;
                got++;
            end
        end
        idle();
        checks++;
        if (stalls != 0 || got != 8 || bad != 0) begin
            errors++;
            $display("FAIL b2b_stream: got stalls=%0d outputs=%0d bad=%0d want 0 8 0", stalls, got, bad);
        end
        checks++;
        if (first != 3 || last - first != 7) begin
            errors++;
            $display("FAIL b2b_timing: got first=%0d span=%0d want 3 7", first, last - first);
        end
    endtask

    task automatic test_backpressure;
        logic [W+1:0] q[$];
        logic [W+1:0] exp;
        logic [W+2:0] snap;
        int sent = 0, got = 0, bad = 0;
        snap = '0;
        for (int c = 0; c < 30; c++) begin
            tick;
            bus.out_ready = (c >= 8);
            if (sent < 5) begin
                beat_data(sent);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (c == 3) snap = {bus.out_valid, bus.ovf, bus.cout, bus.sum};
            if (c == 7) begin
                checks++;
                if (sent != 3 || bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_full: got accepts=%0d in_ready=%b want 3 0", sent, bus.in_ready);
                end
                checks++;
                if ({bus.out_valid, bus.ovf, bus.cout, bus.sum} !== snap ||
                    snap !== {1'b1, model(W'(32'h1357), W'(32'h0F0F), 1'b0, 1'b0)}) begin
                    errors++;
                    $display("FAIL bp_hold: got %h (first seen %h) want stable %h", {bus.out_valid,
                             bus.ovf, bus.cout, bus.sum}, snap,
                             {1'b1, model(W'(32'h1357), W'(32'h0F0F), 1'b0, 1'b0)});
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, bus.cin, bus.op));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : '1;
                if ({bus.ovf, bus.cout, bus.sum} !== exp) bad++;
                got++;
            end
        end
        idle();
        checks++;
        if (got != 5 || bad != 0 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got outputs=%0d bad=%0d left=%0d want 5 0 0", got, bad, q.size());
        end
    endtask

    task automatic test_reset_midstream;
        int extra = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            beat_data(10 + i);
            bus.in_valid = 1'b1;
        end
        tick;
        rst_n = 1'b0;
        beat_data(12);
        bus.in_valid = 1'b1;
        tick;
        rst_n = 1'b1;
        idle();
        #1;
        checks++;
        if ({bus.out_valid, bus.ovf, bus.cout, bus.sum} !== '0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: got v=%b ovf=%b cout=%b sum=%h in_ready=%b want 0 0 0 0000 1",
                     bus.out_valid, bus.ovf, bus.cout, bus.sum, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick;
            #1;
            if (bus.out_valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL midreset_flush: got %0d ghost outputs want 0", extra);
        end
    endtask

    task automatic test_random;
        logic [W+1:0] q[$];
        logic [W+1:0] exp;
        logic [W+1:0] held;
        logic         hold = 1'b0;
        int           n = 0;
        for (int c = 0; c < 3000 + 20; c++) begin
            tick;
            if (c < 3000) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.a         = W'($urandom);
                bus.b         = W'($urandom);
                bus.cin       = 1'($urandom_range(0, 1));
                bus.op        = 1'($urandom_range(0, 1));
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                idle();
                bus.out_ready = 1'b1;
            end
            #1;
            if (hold) begin
                checks++;
                if (bus.out_valid !== 1'b1 || {bus.ovf, bus.cout, bus.sum} !== held) begin
                    errors++;
                    $display("FAIL rand_stall_hold @%0d: got v=%b %h want v=1 %h",
                             c, bus.out_valid, {bus.ovf, bus.cout, bus.sum}, held);
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.cin, bus.op));
            if (bus.out_valid && bus.out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : '1;
                checks++;
                n++;
                if ({bus.ovf, bus.cout, bus.sum} !== exp) begin
                    errors++;
                    $display("FAIL rand_result #%0d: got %h want %h", n, {bus.ovf, bus.cout, bus.sum}, exp);
                end
            end
            hold = bus.out_valid && !bus.out_ready;
            held = {bus.ovf, bus.cout, bus.sum};
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: got %0d results missing want 0", q.size());
        end
    endtask

    initial begin
        idle();
        bus.out_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_ovf();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
